// File: rtl/gpu_cmd_decoder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gpu_cmd_decoder_fifo
// Description : Buffered GPU front-end command decoder. Host commands (4-bit
//               opcode + parameter word) load XY1/XY2/radius staging registers.
//               Draw commands snapshot the staging registers, colour and arc
//               octant into a first-word-fall-through instruction FIFO. The
//               FIFO head is presented to the rasteriser over valid/ready.
// Ports       : clk, n_rst                  clock, async active-low reset
//               command_i/opcode_i/parameters_i/cmd_ready_o   host command
//               instr_valid_o/instr_ready_i                   head handshake
//               opcode_o,x1_o,y1_o,x2_o,y2_o,rad_o,oct_o,r_o,g_o,b_o  head
//               fifo_count_o                 occupied entries
//               illegal_o                    sticky illegal-opcode flag
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_cmd_decoder_fifo #(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int CHANNEL_BITS = 8,
    parameter int PARAM_BITS   = 28,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic                            command_i,
    input  logic [3:0]                      opcode_i,
    input  logic [PARAM_BITS-1:0]           parameters_i,
    output logic                            cmd_ready_o,
    output logic                            instr_valid_o,
    input  logic                            instr_ready_i,
    output logic [3:0]                      opcode_o,
    output logic [WIDTH_BITS-1:0]           x1_o,
    output logic [HEIGHT_BITS-1:0]          y1_o,
    output logic [WIDTH_BITS-1:0]           x2_o,
    output logic [HEIGHT_BITS-1:0]          y2_o,
    output logic [WIDTH_BITS-1:0]           rad_o,
    output logic [2:0]                      oct_o,
    output logic [CHANNEL_BITS-1:0]         r_o,
    output logic [CHANNEL_BITS-1:0]         g_o,
    output logic [CHANNEL_BITS-1:0]         b_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
    output logic                            illegal_o
);

    localparam int W     = WIDTH_BITS;
    localparam int H     = HEIGHT_BITS;
    localparam int C     = CHANNEL_BITS;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0] C_OP_RESET = 4'b0000;
    localparam logic [3:0] C_OP_XY1   = 4'b0001;
    localparam logic [3:0] C_OP_XY2   = 4'b0010;
    localparam logic [3:0] C_OP_RAD   = 4'b0011;
    localparam logic [3:0] C_OP_ARC   = 4'b0111;

    generate
        if ((PARAM_BITS < WIDTH_BITS + HEIGHT_BITS) || (PARAM_BITS - 3 < 3 * CHANNEL_BITS)) begin : g_bad_param_bits
            $error("gpu_cmd_decoder_fifo: PARAM_BITS too narrow for coordinate/colour fields");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("gpu_cmd_decoder_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] x1;
        logic [H-1:0] y1;
        logic [W-1:0] x2;
        logic [H-1:0] y2;
        logic [W-1:0] rad;
        logic [2:0]   oct;
        logic [C-1:0] r;
        logic [C-1:0] g;
        logic [C-1:0] b;
    } entry_t;

    // staging registers
    logic [W-1:0]     r_x1, r_x2, r_rad;
    logic [H-1:0]     r_y1, r_y2;
    // FIFO state
    entry_t           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    entry_t           r_head;
    logic             r_illegal;

    logic             w_accept, w_push, w_pop, w_flush;
    logic [PTR_W-1:0] w_next_rd;
    logic [CNT_W-1:0] w_next_count;
    entry_t           w_new, w_next_head;
    logic             w_unused_params;

    assign cmd_ready_o   = (r_count != C_FULL);
    assign instr_valid_o = (r_count != '0);
    assign w_accept      = command_i && cmd_ready_o;
    assign w_flush       = w_accept && (opcode_i == C_OP_RESET);
    assign w_push        = w_accept && (opcode_i[3:2] == 2'b01);
    assign w_pop         = instr_valid_o && instr_ready_i;

    // Parameter bits that no field consumes in some configurations.
    assign w_unused_params = ^parameters_i;

    always_comb begin
        w_new     = '0;
        w_new.op  = opcode_i;
        w_new.x1  = r_x1;
        w_new.y1  = r_y1;
        w_new.x2  = r_x2;
        w_new.y2  = r_y2;
        w_new.rad = r_rad;
        w_new.oct = (opcode_i == C_OP_ARC) ? parameters_i[PARAM_BITS-1 -: 3] : 3'b000;
        w_new.b   = parameters_i[C-1:0];
        w_new.g   = parameters_i[2*C-1:C];
        w_new.r   = parameters_i[3*C-1:2*C];
    end

    always_comb begin
        w_next_rd    = w_pop ? (r_rd_ptr + 1'b1) : r_rd_ptr;
        w_next_count = r_count;
        case ({w_push, w_pop})
            2'b10:   w_next_count = r_count + 1'b1;
            2'b01:   w_next_count = r_count - 1'b1;
            default: w_next_count = r_count;
        endcase
        // The slot that becomes head may be the one written this cycle
        // (push into empty, or push+pop with one entry): bypass the memory.
        if (w_push && (r_wr_ptr == w_next_rd)) begin
            w_next_head = w_new;
        end else begin
            w_next_head = r_mem[w_next_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_x1      <= '0;
            r_y1      <= '0;
            r_x2      <= '0;
            r_y2      <= '0;
            r_rad     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_head    <= '0;
            r_illegal <= 1'b0;
        end else if (w_flush) begin
            // flush wins over a same-cycle pop; head outputs hold
            r_x1      <= '0;
            r_y1      <= '0;
            r_x2      <= '0;
            r_y2      <= '0;
            r_rad     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                case (opcode_i)
                    C_OP_XY1: begin
                        r_x1 <= parameters_i[W-1:0];
                        r_y1 <= parameters_i[W+H-1:W];
                    end
                    C_OP_XY2: begin
                        r_x2 <= parameters_i[W-1:0];
                        r_y2 <= parameters_i[W+H-1:W];
                    end
                    C_OP_RAD: r_rad <= parameters_i[W-1:0];
                    default:  r_illegal <= r_illegal | opcode_i[3];
                endcase
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_next_rd;
            r_count  <= w_next_count;
            if (w_next_count != '0) begin
                r_head <= w_next_head;
            end
        end
    end

    assign opcode_o     = r_head.op;
    assign x1_o         = r_head.x1;
    assign y1_o         = r_head.y1;
    assign x2_o         = r_head.x2;
    assign y2_o         = r_head.y2;
    assign rad_o        = r_head.rad;
    assign oct_o        = r_head.oct;
    assign r_o          = r_head.r;
    assign g_o          = r_head.g;
    assign b_o          = r_head.b;
    assign fifo_count_o = r_count;
    assign illegal_o    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_gpu_cmd_decoder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_cmd_decoder_fifo
// Description : Directed self-checking bench for gpu_cmd_decoder_fifo with
//               default parameters (W=10, H=9, C=8, PARAM_BITS=28, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_cmd_decoder_fifo;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        command_i = 1'b0;
    logic [3:0]  opcode_i = 4'd0;
    logic [27:0] parameters_i = 28'd0;
    logic        cmd_ready_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [3:0]  opcode_o;
    logic [9:0]  x1_o, x2_o, rad_o;
    logic [8:0]  y1_o, y2_o;
    logic [2:0]  oct_o;
    logic [7:0]  r_o, g_o, b_o;
    logic [2:0]  fifo_count_o;
    logic        illegal_o;

    int errors = 0;
    int checks = 0;

    gpu_cmd_decoder_fifo dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .command_i     (command_i),
        .opcode_i      (opcode_i),
        .parameters_i  (parameters_i),
        .cmd_ready_o   (cmd_ready_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .opcode_o      (opcode_o),
        .x1_o          (x1_o),
        .y1_o          (y1_o),
        .x2_o          (x2_o),
        .y2_o          (y2_o),
        .rad_o         (rad_o),
        .oct_o         (oct_o),
        .r_o           (r_o),
        .g_o           (g_o),
        .b_o           (b_o),
        .fifo_count_o  (fifo_count_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one-cycle command; returns 1ns after the capturing edge
    task automatic send(input logic [3:0] op, input logic [27:0] p);
        @(negedge clk);
        command_i    = 1'b1;
        opcode_i     = op;
        parameters_i = p;
        @(posedge clk);
        #1;
        command_i = 1'b0;
    endtask

    function automatic logic [27:0] xy(input int x, input int y);
        return 28'((y << 10) | x);
    endfunction

    function automatic logic [27:0] rgb(input int r, input int g, input int b);
        return 28'((r << 16) | (g << 8) | b);
    endfunction

    initial begin
        // ---------------- reset state ----------------
        #12;
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_count", 32'(fifo_count_o), 32'd0);
        chk("rst_x1", 32'(x1_o), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;

        // ---------------- single line, ready high ----------------
        instr_ready_i = 1'b1;
        send(4'b0001, xy(100, 50));
        send(4'b0010, xy(300, 200));
        send(4'b0100, rgb(8'hFF, 8'h80, 8'h01));
        chk("l_valid", 32'(instr_valid_o), 32'd1);
        chk("l_op", 32'(opcode_o), 32'd4);
        chk("l_x1", 32'(x1_o), 32'd100);
        chk("l_y1", 32'(y1_o), 32'd50);
        chk("l_x2", 32'(x2_o), 32'd300);
        chk("l_y2", 32'(y2_o), 32'd200);
        chk("l_rgb", {8'd0, r_o, g_o, b_o}, 32'hFF8001);
        chk("l_oct", 32'(oct_o), 32'd0);
        @(posedge clk); #1;
        chk("l_popped_valid", 32'(instr_valid_o), 32'd0);
        chk("l_popped_count", 32'(fifo_count_o), 32'd0);

        // ---------------- fill to full, 5th held ----------------
        instr_ready_i = 1'b0;
        send(4'b0100, rgb(0, 0, 1));
        send(4'b0101, rgb(0, 0, 2));
        send(4'b0110, rgb(0, 0, 3));
        send(4'b0111, rgb(0, 0, 4));
        chk("full_count", 32'(fifo_count_o), 32'd4);
        chk("full_ready", 32'(cmd_ready_o), 32'd0);
        @(negedge clk);
        command_i    = 1'b1;
        opcode_i     = 4'b0100;
        parameters_i = rgb(0, 0, 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("held_count", 32'(fifo_count_o), 32'd4);
        chk("held_ready", 32'(cmd_ready_o), 32'd0);
        chk("head0", {24'd0, opcode_o, b_o[3:0]}, 32'h41);
        instr_ready_i = 1'b1;
        @(posedge clk); #1;      // pop only (was full)
        chk("pop_full_count", 32'(fifo_count_o), 32'd3);
        chk("pop_full_ready", 32'(cmd_ready_o), 32'd1);
        chk("head1", {24'd0, opcode_o, b_o[3:0]}, 32'h52);
        @(posedge clk); #1;      // push of held 5th + pop
        command_i = 1'b0;
        chk("pushpop_count", 32'(fifo_count_o), 32'd3);
        chk("head2", {24'd0, opcode_o, b_o[3:0]}, 32'h63);
        @(posedge clk); #1;
        chk("head3", {24'd0, opcode_o, b_o[3:0]}, 32'h74);
        @(posedge clk); #1;
        chk("head4", {24'd0, opcode_o, b_o[3:0]}, 32'h45);
        chk("head4_count", 32'(fifo_count_o), 32'd1);
        @(posedge clk); #1;
        chk("drain_valid", 32'(instr_valid_o), 32'd0);

        // ---------------- arc then circle ----------------
        instr_ready_i = 1'b0;
        send(4'b0011, 28'd40);
        send(4'b0111, (28'd5 << 25) | rgb(1, 2, 3));
        chk("arc_op", 32'(opcode_o), 32'd7);
        chk("arc_oct", 32'(oct_o), 32'd5);
        chk("arc_rad", 32'(rad_o), 32'd40);
        send(4'b0110, (28'd5 << 25) | rgb(1, 2, 3));
        instr_ready_i = 1'b1;
        @(posedge clk); #1;
        instr_ready_i = 1'b0;
        chk("circ_op", 32'(opcode_o), 32'd6);
        chk("circ_oct", 32'(oct_o), 32'd0);
        chk("circ_rad", 32'(rad_o), 32'd40);
        instr_ready_i = 1'b1;
        @(posedge clk); #1;
        instr_ready_i = 1'b0;
        chk("arc_drain", 32'(fifo_count_o), 32'd0);

        // ---------------- snapshot isolation ----------------
        send(4'b0100, rgb(0, 0, 9));
        send(4'b0001, xy(7, 50));
        chk("snap_old_x1", 32'(x1_o), 32'd100);
        send(4'b0101, rgb(0, 0, 9));
        instr_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("snap_new_x1", 32'(x1_o), 32'd7);
        chk("snap_new_op", 32'(opcode_o), 32'd5);
        @(posedge clk); #1;
        instr_ready_i = 1'b0;
        chk("snap_drain", 32'(fifo_count_o), 32'd0);

        // ---------------- illegal opcode and flush ----------------
        send(4'b0100, rgb(0, 0, 1));
        send(4'b0100, rgb(0, 0, 2));
        send(4'b1010, 28'd0);
        chk("ill_flag", 32'(illegal_o), 32'd1);
        chk("ill_count", 32'(fifo_count_o), 32'd2);
        instr_ready_i = 1'b1;
        send(4'b0000, 28'd0);
        chk("flush_count", 32'(fifo_count_o), 32'd0);
        chk("flush_valid", 32'(instr_valid_o), 32'd0);
        chk("flush_illegal", 32'(illegal_o), 32'd0);
        instr_ready_i = 1'b0;
        send(4'b0110, rgb(0, 0, 0));
        chk("flush_staging_x1", 32'(x1_o), 32'd0);
        chk("flush_staging_x2", 32'(x2_o), 32'd0);
        instr_ready_i = 1'b1;
        @(posedge clk); #1;
        instr_ready_i = 1'b0;

        // ---------------- async reset mid-queue ----------------
        send(4'b0001, xy(5, 6));
        send(4'b0011, 28'd9);
        send(4'b0100, rgb(1, 1, 1));
        send(4'b0101, rgb(1, 1, 1));
        send(4'b0110, rgb(1, 1, 1));
        chk("pre_rst_count", 32'(fifo_count_o), 32'd3);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_count", 32'(fifo_count_o), 32'd0);
        chk("arst_valid", 32'(instr_valid_o), 32'd0);
        chk("arst_head", {11'd0, opcode_o, x1_o, rad_o, 1'b0}, 32'd0);
        chk("arst_rgb", {8'd0, r_o, g_o, b_o}, 32'd0);
        chk("arst_ready", 32'(cmd_ready_o), 32'd1);
        @(negedge clk);
        n_rst = 1'b1;
        send(4'b0100, rgb(0, 0, 3));
        chk("post_valid", 32'(instr_valid_o), 32'd1);
        chk("post_xy", {3'd0, x1_o, y1_o, x2_o}, 32'd0);
        chk("post_y2_rad", {13'd0, y2_o, rad_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpu_cmd_decoder_fifo.md
Name: gpu_cmd_decoder_fifo

Overview:
- Parametrised, buffered command decoder for the GPU front end.
- Decodes 4-bit opcode plus parameter-word commands into staging registers (XY1, XY2, radius).
- On each draw command, snapshots staging registers, colour and octant into an internal instruction FIFO.
- Presents the FIFO head to the rasteriser over a valid/ready handshake, so the host can queue draws while the rasteriser is busy.

Parameters:
- WIDTH_BITS, 10: x coordinate / radius width.
- HEIGHT_BITS, 9: y coordinate width.
- CHANNEL_BITS, 8: per-channel colour width.
- PARAM_BITS, 28: command parameter word width. Elaboration error unless PARAM_BITS >= WIDTH_BITS+HEIGHT_BITS and PARAM_BITS-3 >= 3*CHANNEL_BITS.
- FIFO_DEPTH, 4: instruction FIFO entries. Must be a power of two, >= 2.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- command_i  in  1  command strobe.
- opcode_i  in  4  command opcode.
- parameters_i  in  PARAM_BITS  command parameters.
- cmd_ready_o  out  1  command accepted this cycle if command_i=1.
- instr_valid_o  out  1  FIFO head valid.
- instr_ready_i  in  1  rasteriser consumes head.
- opcode_o  out  4  head opcode (4..7).
- x1_o / x2_o  out  WIDTH_BITS  head endpoints x.
- y1_o / y2_o  out  HEIGHT_BITS  head endpoints y.
- rad_o  out  WIDTH_BITS  head radius.
- oct_o  out  3  head arc octant mask (0 for non-arc).
- r_o / g_o / b_o  out  CHANNEL_BITS  head colour.
- fifo_count_o  out  $clog2(FIFO_DEPTH+1)  occupied entries.
- illegal_o  out  1  sticky illegal-opcode flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on n_rst.
- Reset values: all staging registers, FIFO pointers, fifo_count_o, illegal_o, and all head outputs are 0. instr_valid_o=0, cmd_ready_o=1.
- Acceptance: a command is accepted when command_i && cmd_ready_o. cmd_ready_o = (count != FIFO_DEPTH); every opcode stalls when full. Unaccepted commands cause no state change; the host holds them.
- 0000 reset_state:
  - Clears staging registers and illegal_o.
  - Flushes FIFO: pointers and count to 0; instr_valid_o=0 next cycle.
  - Takes priority over a simultaneous pop.
- 0001 set_xy1: x1 = params[W-1:0]; y1 = params[W+H-1:W]. No push.
- 0010 set_xy2: same field slicing into x2/y2. No push.
- 0011 set_radius: rad = params[W-1:0]. No push.
- 0100 line, 0101 rect, 0110 circle, 0111 arc: push one entry.
  - Entry contents: opcode; current staging x1,y1,x2,y2,rad; b = params[C-1:0]; g = params[2C-1:C]; r = params[3C-1:2C].
  - oct = params[PARAM_BITS-1:PARAM_BITS-3] for arc, 0 otherwise.
  - Snapshot uses staging values from before this cycle.
- 1000-1111: not pushed; set illegal_o=1 next cycle. Flag stays set until opcode 0000 or n_rst.
- Output and latency:
  - FIFO is first-word-fall-through. Head outputs are registered from the entry at the read pointer; instr_valid_o = (count != 0).
  - A draw accepted into an empty FIFO gives instr_valid_o=1 the following cycle.
- Pop: occurs on instr_valid_o && instr_ready_i. Head advances next cycle. Head outputs hold their last value when empty.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pop when full: count decrements, cmd_ready_o rises next cycle. No same-cycle push, since cmd_ready_o was 0.
- Pointers wrap modulo FIFO_DEPTH.
- instr_ready_i while empty is ignored.
- n_rst mid-operation discards all queued entries immediately.

Test Plan:
- set_xy1 params x=100,y=50; set_xy2 x=300,y=200; line params r=0xFF g=0x80 b=0x01 (instr_ready_i=1) -> one cycle later instr_valid_o=1, opcode_o=4, x1=100,y1=50,x2=300,y2=200, r/g/b=FF/80/01, oct=0; popped, valid drops.
- instr_ready_i=0; issue 5 draws (depth 4) -> count reaches 4, cmd_ready_o=0, 5th held. Release ready -> 5 entries pop in order with correct opcodes.
- Arc with params[27:25]=3'b101, radius 40 -> head oct_o=5, rad_o=40, opcode_o=7. Following circle -> oct_o=0.
- Queue a line, then set_xy1 x=7 before pop -> popped entry keeps the old x1. Next draw carries x1=7.
- opcode 1010 -> illegal_o=1, count unchanged. opcode 0000 with 2 entries queued and instr_ready_i=1 -> count 0, valid 0, illegal_o 0.
- Assert n_rst low mid-queue (3 entries) -> all outputs 0 asynchronously. After release, first draw reports x1=y1=x2=y2=rad=0.
